shift_collector: RTL and testbench

- Receive side of the ALU shift register's serial output: captures the bit shifted out on each LSH/RSH step (the shifter FLAG) and reassembles a WIDTH-bit word.
- Direction-aware, so a word shifted out either way is rebuilt in its original bit order.
- Single-entry output buffer with valid/ready handshake toward the register file / accumulator path.
- Sticky overrun flag reports a completed word dropped because the buffer was still full.

---
 rtl/shift_collector_pkg.sv | 16 +
 rtl/shift_collector_outbuf.sv | 59 +++++
 rtl/shift_collector.sv | 92 +++++++++
 tb/tb_shift_collector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_collector_pkg.sv
// Shared ALU definitions for the shift collector.
// Shift direction encoding, assembly states and default width.
package shift_collector_pkg;

  localparam int SC_WIDTH = 4;
  localparam int SC_CNT_W = 3;

  localparam logic DIR_RSH = 1'b0;
  localparam logic DIR_LSH = 1'b1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_e;

endpackage

// File: rtl/shift_collector_outbuf.sv
// Single-entry valid/ready holding register.
// Flags a sticky overrun when a word arrives while full.
module shift_collector_outbuf
  import shift_collector_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             ready_i,
  input  logic             clr_ovr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             pop;

  assign pop = valid_q & ready_i;

  // Next state: load when room (or freed this edge), else drop.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (push_i && (!valid_q || pop)) begin
      data_d  = push_data_i;
      valid_d = 1'b1;
    end else if (push_i) begin
      ovr_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
    if (clr_ovr_i) ovr_d = 1'b0;
  end

  // Buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/shift_collector.sv
// Reassembles words from the ALU shifter's serial FLAG output.
// Direction is latched on the first bit and holds for the word.
module shift_collector
  import shift_collector_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH,
  parameter int CNT_W = SC_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BIT_IN,
  input  logic             BIT_VALID,
  input  logic             DIR,
  input  logic             CLEAR,
  output logic [WIDTH-1:0] WORD_OUT,
  output logic             WORD_VALID,
  input  logic             WORD_READY,
  output logic             BUSY,
  output logic             OVERRUN
);

  asm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic             dir_q, dir_d;
  logic             eff_dir;
  logic             last_bit;
  logic             complete;
  logic [WIDTH-1:0] ins;

  assign eff_dir  = (state_q == ST_IDLE) ? DIR : dir_q;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign complete = BIT_VALID & ~CLEAR & last_bit;
  assign ins = (eff_dir == DIR_LSH)
             ? {asm_q[WIDTH-2:0], BIT_IN}
             : {BIT_IN, asm_q[WIDTH-1:1]};

  // Assembly FSM next state: CLEAR beats any incoming bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    dir_d   = dir_q;
    if (CLEAR) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      asm_d   = '0;
    end else if (BIT_VALID) begin
      asm_d = ins;
      dir_d = eff_dir;
      if (last_bit) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_COLLECT;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // Assembly state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      dir_q   <= DIR_RSH;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      dir_q   <= dir_d;
    end
  end

  assign BUSY = (state_q == ST_COLLECT);

  shift_collector_outbuf #(
    .WIDTH (WIDTH)
  ) u_outbuf (
    .clk         (CLK),
    .rst         (RESET),
    .push_i      (complete),
    .push_data_i (ins),
    .ready_i     (WORD_READY),
    .clr_ovr_i   (CLEAR),
    .data_o      (WORD_OUT),
    .valid_o     (WORD_VALID),
    .overrun_o   (OVERRUN)
  );

endmodule

// File: tb/tb_shift_collector.sv
// Bench for shift_collector: directed scenarios plus random
// traffic against a bit-list reference model.
module tb_shift_collector;

  localparam int W = 4;
  localparam int C = 3;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         BIT_IN = 1'b0;
  logic         BIT_VALID = 1'b0;
  logic         DIR = 1'b0;
  logic         CLEAR = 1'b0;
  logic         WORD_READY = 1'b0;
  logic [W-1:0] WORD_OUT;
  logic         WORD_VALID;
  logic         BUSY;
  logic         OVERRUN;

  shift_collector #(
    .WIDTH (W),
    .CNT_W (C)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BIT_IN     (BIT_IN),
    .BIT_VALID  (BIT_VALID),
    .DIR        (DIR),
    .CLEAR      (CLEAR),
    .WORD_OUT   (WORD_OUT),
    .WORD_VALID (WORD_VALID),
    .WORD_READY (WORD_READY),
    .BUSY       (BUSY),
    .OVERRUN    (OVERRUN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: bits received so far, in arrival order.
  bit           mq[$];
  bit           mdir = 1'b0;
  logic [W-1:0] mout = '0;
  bit           mval = 1'b0;
  bit           movr = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word from arrival-ordered bits: RSH sends LSB first,
  // LSH sends MSB first.
  function automatic logic [W-1:0] form_word(input bit d);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (d) w[W-1-i] = mq[i];
      else   w[i]     = mq[i];
    end
    return w;
  endfunction

  task automatic model(input bit rst, input bit bv, input bit b,
                       input bit d, input bit clr, input bit rdy);
    bit           pop;
    bit           done;
    logic [W-1:0] word;
    done = 1'b0;
    word = '0;
    if (rst) begin
      mq.delete();
      mdir = 1'b0;
      mout = '0;
      mval = 1'b0;
      movr = 1'b0;
      return;
    end
    pop = mval && rdy;
    if (clr) begin
      mq.delete();
      movr = 1'b0;
    end else if (bv) begin
      if (mq.size() == 0) mdir = d;
      mq.push_back(b);
      if (mq.size() == W) begin
        word = form_word(mdir);
        mq.delete();
        done = 1'b1;
      end
    end
    if (done && (!mval || pop)) begin
      mout = word;
      mval = 1'b1;
    end else if (done) begin
      movr = 1'b1;
    end else if (pop) begin
      mval = 1'b0;
    end
  endtask

  task automatic step(input bit rst, input bit bv, input bit b,
                      input bit d, input bit clr, input bit rdy);
    RESET      = rst;
    BIT_VALID  = bv;
    BIT_IN     = b;
    DIR        = d;
    CLEAR      = clr;
    WORD_READY = rdy;
    model(rst, bv, b, d, clr, rdy);
    @(posedge CLK);
    #1;
    chk("word_out", 32'(WORD_OUT), 32'(mout));
    chk("word_valid", 32'(WORD_VALID), 32'(mval));
    chk("busy", 32'(BUSY), 32'(mq.size() != 0));
    chk("overrun", 32'(OVERRUN), 32'(movr));
  endtask

  task automatic bit_(input bit b, input bit d, input bit rdy);
    step(1'b0, 1'b1, b, d, 1'b0, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    #2;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_out", 32'(WORD_OUT), 32'h0);
    chk("rst_valid", 32'(WORD_VALID), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // RSH round trip: 1,0,1,1 -> 1101
    bit_(1, 0, 0); bit_(0, 0, 0); bit_(1, 0, 0); bit_(1, 0, 0);
    chk("rsh_word", 32'(WORD_OUT), 32'hD);
    chk("rsh_valid", 32'(WORD_VALID), 32'h1);
    chk("rsh_busy", 32'(BUSY), 32'h0);
    idle(1);

    // LSH round trip with DIR toggling mid-word: 1,1,0,1 -> 1101
    bit_(1, 1, 0); bit_(1, 0, 0); bit_(0, 1, 0); bit_(1, 0, 0);
    chk("lsh_word", 32'(WORD_OUT), 32'hD);
    idle(1);

    // Overrun: 1000 held, 0110 dropped.
    bit_(1, 1, 0); bit_(0, 1, 0); bit_(0, 1, 0); bit_(0, 1, 0);
    bit_(0, 1, 0); bit_(1, 1, 0); bit_(1, 1, 0); bit_(0, 1, 0);
    chk("ovr_word", 32'(WORD_OUT), 32'h8);
    chk("ovr_flag", 32'(OVERRUN), 32'h1);
    idle(1);
    chk("pop_valid", 32'(WORD_VALID), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovr", 32'(OVERRUN), 32'h0);

    // Simultaneous pop and complete: 1001 held, 0011 arrives.
    bit_(1, 1, 0); bit_(0, 1, 0); bit_(0, 1, 0); bit_(1, 1, 0);
    bit_(0, 1, 0); bit_(0, 1, 0); bit_(1, 1, 0); bit_(1, 1, 1);
    chk("bb_word", 32'(WORD_OUT), 32'h3);
    chk("bb_valid", 32'(WORD_VALID), 32'h1);
    chk("bb_ovr", 32'(OVERRUN), 32'h0);
    idle(1);

    // Gaps, then CLEAR after 2 bits.
    bit_(0, 0, 0); idle(0); bit_(1, 0, 0); idle(0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_busy", 32'(BUSY), 32'h0);
    bit_(0, 0, 0); bit_(1, 0, 0); idle(0); bit_(1, 0, 0);
    bit_(0, 0, 0);
    chk("gap_word", 32'(WORD_OUT), 32'h6);
    idle(0);

    // Reset mid-word with a full buffer.
    bit_(1, 0, 0); bit_(1, 0, 0); bit_(1, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mrst_out", 32'(WORD_OUT), 32'h0);
    chk("mrst_busy", 32'(BUSY), 32'h0);
    bit_(0, 1, 0); bit_(1, 1, 0); bit_(0, 1, 0); bit_(1, 1, 0);
    chk("mrst_word", 32'(WORD_OUT), 32'h5);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 70,
           1'($urandom),
           1'($urandom),
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 45);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
